// File: rtl/simd_result_collector_pkg.sv
// rtl/simd_result_collector_pkg.sv - shared constants and entry word order
// Contents: lane count, words per entry, default word width and the table
// that maps an out_index to its source lane and result/extra selection.
package simd_result_collector_pkg;

  localparam int LANES           = 4;
  localparam int WORDS_PER_ENTRY = 8;
  localparam int DEFAULT_WIDTH   = 32;

  typedef struct packed {
    logic [1:0] lane;
    logic       is_ext;
  } word_src_t;

  // out_index 0..7 -> res0, ext0, res1, ext1, res2, ext2, res3, ext3
  localparam word_src_t WORD_ORDER [WORDS_PER_ENTRY] = '{
    '{lane: 2'd0, is_ext: 1'b0},
    '{lane: 2'd0, is_ext: 1'b1},
    '{lane: 2'd1, is_ext: 1'b0},
    '{lane: 2'd1, is_ext: 1'b1},
    '{lane: 2'd2, is_ext: 1'b0},
    '{lane: 2'd2, is_ext: 1'b1},
    '{lane: 2'd3, is_ext: 1'b0},
    '{lane: 2'd3, is_ext: 1'b1}
  };

endpackage

// File: rtl/simd_result_collector_if.sv
// rtl/simd_result_collector_if.sv - capture inputs, word stream and status bundle
// Signals: procc_done/res0..3/ext0..3 (capture side), out_data/out_valid/
// out_ready/out_last/out_index (word stream), full/empty/count/overflow (status).
// slave = the collector, master = the producer/consumer environment.
interface simd_result_collector_if
  import simd_result_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
);

  logic                     procc_done;
  logic [WIDTH-1:0]         res0, res1, res2, res3;
  logic [WIDTH-1:0]         ext0, ext1, ext2, ext3;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [2:0]               out_index;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output procc_done, res0, res1, res2, res3, ext0, ext1, ext2, ext3, out_ready,
    input  out_data, out_valid, out_last, out_index, full, empty, count, overflow
  );

  modport slave (
    input  procc_done, res0, res1, res2, res3, ext0, ext1, ext2, ext3, out_ready,
    output out_data, out_valid, out_last, out_index, full, empty, count, overflow
  );

endinterface

// File: rtl/simd_result_collector_result_fifo.sv
// rtl/simd_result_collector_result_fifo.sv - entry storage with pointers and count
// Ports: clk, reset (async, active-high), wr_en/wr_data (one whole entry),
// pop (retire head entry), head_data, full, empty, count.
// The caller never writes when full nor pops when empty.
module simd_result_collector_result_fifo
  import simd_result_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = WORDS_PER_ENTRY * DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [EW-1:0]          wr_data,
  input  logic                   pop,
  output logic [EW-1:0]          head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage carries no reset; reset discards entries through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/simd_result_collector.sv
// rtl/simd_result_collector.sv - capture lane results on done, stream entries as words
// Ports: clk, reset (async, active-high), bus (slave modport of
// simd_result_collector_if carrying capture inputs, word stream and status).
module simd_result_collector
  import simd_result_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  simd_result_collector_if.slave bus
);

  localparam int EW = WORDS_PER_ENTRY * WIDTH;

  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [2:0]       widx_q, widx_d;
  logic             capture, wr_en, xfer, pop;
  logic             full, empty;
  logic [EW-1:0]    entry, head_data;
  logic [WIDTH-1:0] res_w [LANES];
  logic [WIDTH-1:0] ext_w [LANES];

  assign res_w[0] = bus.res0;
  assign res_w[1] = bus.res1;
  assign res_w[2] = bus.res2;
  assign res_w[3] = bus.res3;
  assign ext_w[0] = bus.ext0;
  assign ext_w[1] = bus.ext1;
  assign ext_w[2] = bus.ext2;
  assign ext_w[3] = bus.ext3;

  // Only the rising edge captures, so a long done level yields one entry.
  assign capture = bus.procc_done & ~done_q;
  // Fullness is judged before this cycle's pop: a slot freed now is not reusable yet.
  assign wr_en   = capture & ~full;
  assign xfer    = ~empty & bus.out_ready;
  assign pop     = xfer & (widx_q == 3'd7);

  always_comb begin
    entry = '0;
    for (int i = 0; i < WORDS_PER_ENTRY; i++) begin
      entry[i*WIDTH +: WIDTH] = WORD_ORDER[i].is_ext ? ext_w[WORD_ORDER[i].lane]
                                                     : res_w[WORD_ORDER[i].lane];
    end
  end

  simd_result_collector_result_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (entry),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (bus.count)
  );

  always_comb begin
    done_d     = bus.procc_done;
    overflow_d = overflow_q | (capture & full);
    widx_d     = xfer ? widx_q + 3'd1 : widx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      widx_q     <= 3'd0;
    end else begin
      done_q     <= done_d;
      overflow_q <= overflow_d;
      widx_q     <= widx_d;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : head_data[int'(widx_q)*WIDTH +: WIDTH];
  assign bus.out_index = widx_q;
  assign bus.out_last  = ~empty & (widx_q == 3'd7);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_simd_result_collector.sv
// tb/tb_simd_result_collector.sv - directed and random checks against a word-queue model
module tb_simd_result_collector;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  simd_result_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  simd_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: flat queue of words still to be streamed, in stream order.
  logic [31:0] wq [$];
  bit          ovf_m       = 1'b0;
  bit          done_prev_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after a negedge with inputs already driven; advances one cycle.
  task automatic cycle();
    int          sz;
    int          ent;
    int          r;
    bit          v;
    bit          xfer;
    bit          cap;
    logic [31:0] exp_data;
    #1;
    sz       = wq.size();
    ent      = (sz + 7) / 8;
    v        = (sz > 0);
    exp_data = v ? wq[0] : 32'h0;
    r        = v ? ((sz - 1) % 8) + 1 : 8;
    chk("out_valid", 32'(bus.out_valid), 32'(v));
    chk("out_data", bus.out_data, exp_data);
    chk("out_index", 32'(bus.out_index), 32'(8 - r));
    chk("out_last", 32'(bus.out_last), 32'(v && r == 1));
    chk("count", 32'(bus.count), 32'(ent));
    chk("full", 32'(bus.full), 32'(ent == DEPTH));
    chk("empty", 32'(bus.empty), 32'(ent == 0));
    chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    xfer = v && bus.out_ready;
    cap  = !reset && bus.procc_done && !done_prev_m;
    if (cap) begin
      if (ent == DEPTH) ovf_m = 1'b1;
      else begin
        wq.push_back(bus.res0); wq.push_back(bus.ext0);
        wq.push_back(bus.res1); wq.push_back(bus.ext1);
        wq.push_back(bus.res2); wq.push_back(bus.ext2);
        wq.push_back(bus.res3); wq.push_back(bus.ext3);
      end
    end
    if (xfer && !reset) void'(wq.pop_front());
    done_prev_m = reset ? 1'b0 : bus.procc_done;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lanes(input logic [31:0] rb, input logic [31:0] eb);
    bus.res0 = rb;      bus.res1 = rb + 1; bus.res2 = rb + 2; bus.res3 = rb + 3;
    bus.ext0 = eb;      bus.ext1 = eb + 1; bus.ext2 = eb + 2; bus.ext3 = eb + 3;
  endtask

  task automatic set_random();
    bus.res0 = $urandom; bus.res1 = $urandom; bus.res2 = $urandom; bus.res3 = $urandom;
    bus.ext0 = $urandom; bus.ext1 = $urandom; bus.ext2 = $urandom; bus.ext3 = $urandom;
  endtask

  task automatic do_capture(input int n_high);
    bus.procc_done = 1'b1;
    repeat (n_high) cycle();
    bus.procc_done = 1'b0;
    cycle();
  endtask

  task automatic run_until_size(input int target, input int budget);
    int n = 0;
    while (wq.size() != target && n < budget) begin
      cycle();
      n++;
    end
    chk("reach_size", 32'(wq.size()), 32'(target));
  endtask

  task automatic do_reset();
    bus.procc_done = 1'b0;
    reset = 1'b1;
    wq.delete();
    ovf_m = 1'b0;
    done_prev_m = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    bus.procc_done = 1'b0;
    bus.out_ready = 1'b0;
    set_lanes(32'h0, 32'h0);
    @(negedge clk);
    do_reset();

    // Single capture, done held 3 cycles
    set_lanes(32'h10, 32'h20);
    bus.out_ready = 1'b1;
    do_capture(3);
    run_until_size(0, 20);
    cycle();

    // Stall at widx 3 for 5 cycles
    set_lanes(32'h10, 32'h20);
    do_capture(1);
    run_until_size(5, 20);
    bus.out_ready = 1'b0;
    repeat (5) cycle();
    bus.out_ready = 1'b1;
    run_until_size(0, 20);

    // Fill and overflow
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_random();
      do_capture(1);
    end
    chk("ovf_after_fill", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    run_until_size(0, 60);

    // Capture coinciding with final-word pop at count 2
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_random();
      do_capture(1);
    end
    bus.out_ready = 1'b1;
    run_until_size(9, 20);
    set_random();
    bus.procc_done = 1'b1;
    cycle();
    bus.procc_done = 1'b0;
    run_until_size(0, 40);

    // Capture coinciding with final-word pop at count 4
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_random();
      do_capture(1);
    end
    bus.out_ready = 1'b1;
    run_until_size(25, 20);
    set_random();
    bus.procc_done = 1'b1;
    cycle();
    bus.procc_done = 1'b0;
    run_until_size(0, 40);

    // Reset with 2 entries stored and widx 5
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_random();
      do_capture(1);
    end
    bus.out_ready = 1'b1;
    run_until_size(11, 20);
    do_reset();
    set_lanes(32'hA0, 32'hB0);
    do_capture(1);
    run_until_size(0, 20);

    // Back-to-back entries
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_random();
      do_capture(1);
    end
    bus.out_ready = 1'b1;
    repeat (16) cycle();
    chk("b2b_drained", 32'(bus.empty), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_random();
      if ($urandom_range(0, 3) == 0) bus.procc_done = ~bus.procc_done;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.procc_done = 1'b0;
    bus.out_ready = 1'b1;
    run_until_size(0, 60);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simd_result_collector.md
# simd_result_collector

Downstream stage of the SIMD top level. Captures the four lanes' result and extra-result words (eight 32-bit words) when the processors report done, and buffers them as one entry in a small FIFO. Drains each entry as a 32-bit valid/ready word stream for the memory controller write-back or the host port.

## Interface
Parameters:
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- WIDTH, 32: lane word width.

Ports:
- clk: input, 1. Single clock, rising edge.
- reset: input, 1. Asynchronous, active-high.
- procc_done: input, 1. AND of the four lane done flags. Level signal, held high for at least 1 clk cycle.
- res0, res1, res2, res3: input, WIDTH each. Lane results.
- ext0, ext1, ext2, ext3: input, WIDTH each. Lane extra results.
- out_data: output, WIDTH. Current word.
- out_valid: output, 1. out_data is valid.
- out_ready: input, 1. Consumer accepts the word.
- out_last: output, 1. Current word is word 7 of its entry.
- out_index: output, 3. Word position 0..7 inside the entry.
- full: output, 1. count == DEPTH.
- empty: output, 1. count == 0.
- count: output, $clog2(DEPTH)+1. Number of stored entries.
- overflow: output, 1. Sticky flag: a capture was dropped.

## Operation
- **Capture event**: procc_done rising edge, detected against a registered copy of procc_done (done_q, reset 0).
  - On the event, the eight inputs are sampled in the same cycle.
  - If not full, they are written as one entry at the write pointer.
- **Entry word order** (out_index 0..7): res0, ext0, res1, ext1, res2, ext2, res3, ext3.
- **Serializer**:
  - Head entry, word counter widx (3 bits).
  - out_valid = !empty. out_data = head word[widx]. out_index = widx. out_last = (widx == 7).
- **Handshake**: a transfer happens when out_valid && out_ready.
  - On a transfer, widx increments.
  - On a transfer with widx == 7, widx wraps to 0, the read pointer advances and count decrements.
- **Consumer rules**: out_valid must not drop while out_ready is low, except on reset. out_data must stay stable while stalled.
- **FIFO**: read and write pointers of $clog2(DEPTH) bits, both wrapping modulo DEPTH.
- **Full on capture event**:
  - The capture is dropped and overflow is set.
  - This holds even if the head entry's final word transfers in the same cycle; the freed slot is not reusable until the next cycle.
  - Stored data is unaffected.
- **Simultaneous capture (not full) and final-word pop**: the write and the read both happen, and count is unchanged.
- **overflow** clears only on reset.
- **Reset**:
  - Asserting reset at any time, including mid-entry, discards all entries.
  - widx = 0, pointers = 0, count = 0, empty = 1, full = 0, overflow = 0, out_valid = 0, out_last = 0, out_index = 0.
  - out_data reads 0 whenever out_valid is low.

## Timing
- **Capture latency**: procc_done high in cycle k, low in cycle k-1 → entry written at the end of cycle k. out_valid is high in cycle k+1 if the FIFO was empty.
- **Throughput**: one word per cycle while out_ready is high, so one entry takes 8 cycles. Back-to-back entries have no bubble at the out_last to index-0 boundary.
- **Sustained done**: procc_done held high for N cycles produces exactly one capture.
- **Output path**: out_data, out_last and out_index are combinational from registered state (pointers, widx, storage). There is no input-to-output combinational path except through out_ready, which feeds only next-state logic.

## Structure
- **simd_pkg** holds:
  - Lane count (4).
  - WORDS_PER_ENTRY (8).
  - Default WIDTH.
  - The word-order constant mapping out_index to {lane, result/extra}.
- **Sub-module result_fifo** holds the entry storage (DEPTH x 8·WIDTH), the pointers and count, and produces full and empty. It has a one-entry write port and a pop strobe.
- **Top level** holds the edge detector, overflow flag, widx counter and output mux.

## Test plan
- **Single capture**:
  - Stimulus: after reset, res0..3 = 0x10..0x13, ext0..3 = 0x20..0x23. Pulse procc_done for 3 cycles. out_ready held high.
  - Required response: exactly 8 words 0x10, 0x20, 0x11, 0x21, 0x12, 0x22, 0x13, 0x23. out_last only on 0x23. Then empty = 1.
- **Stall**: same capture with out_ready low for 5 cycles at widx = 3 → out_data stays 0x21, out_valid stays high, no word is lost or duplicated.
- **Fill and overflow**:
  - Stimulus: 5 captures with out_ready low.
  - Required response: count = 4, full = 1, overflow = 1. The drain returns the first 4 entries in order. The 5th entry is absent.
- **Same-cycle events**: capture event in the same cycle as a final-word pop.
  - At count = 2: count stays 2, and the new entry appears after the remaining one.
  - At count = 4: the capture is dropped and overflow is set.
- **Reset mid-entry**: assert reset while widx = 5 with 2 entries stored → all outputs at reset values next edge. A new capture afterwards streams from word 0.
- **Back-to-back**: 2 entries drained with out_ready always high → 16 consecutive transfers, out_last on the 8th and 16th.
